// File: rtl/tt_um_emern_tri_setup_pkg.sv
// Shared widths, screen limits, FSM state encoding and delta helper for the triangle setup stage.
package tt_um_emern_tri_setup_pkg;

  localparam int unsigned COORD_W  = 6;
  localparam int unsigned X_W      = COORD_W;
  localparam int unsigned Y_W      = COORD_W;
  localparam int unsigned DELTA_W  = 7;
  localparam int unsigned PROD_W   = 2 * DELTA_W;
  localparam int unsigned DET_W    = 13;
  localparam int unsigned SCREEN_W = 64;
  localparam int unsigned SCREEN_H = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL0 = 2'd1,
    ST_MUL1 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // a - b of two unsigned coordinates; the low 7 bits of a zero-extended subtract.
  function automatic logic signed [DELTA_W-1:0] delta7(input logic [COORD_W-1:0] a,
                                                       input logic [COORD_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/tt_um_emern_tri_setup_if.sv
// Vertex-in / determinant-out handshake bundle between the setup stage and its neighbours.
interface tt_um_emern_tri_setup_if;
  import tt_um_emern_tri_setup_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [X_W-1:0]            x0, x1, x2;
  logic [Y_W-1:0]            y0, y1, y2;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DET_W-1:0]   determinant;
  logic signed [DELTA_W-1:0] dx10, dy10, dx20, dy20;
  logic                      degenerate;
  logic                      cull;

  modport master (
    output in_valid, x0, x1, x2, y0, y1, y2, out_ready,
    input  in_ready, out_valid, determinant, dx10, dy10, dx20, dy20, degenerate, cull
  );

  modport slave (
    input  in_valid, x0, x1, x2, y0, y1, y2, out_ready,
    output in_ready, out_valid, determinant, dx10, dy10, dx20, dy20, degenerate, cull
  );

endinterface

// File: rtl/tt_um_emern_smul7.sv
// Signed 7x7 -> 14 multiplier with registered operands; the parent muxes operands each cycle.
module tt_um_emern_smul7
  import tt_um_emern_tri_setup_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DELTA_W-1:0] a,
  input  logic signed [DELTA_W-1:0] b,
  output logic signed [PROD_W-1:0]  prod_c
);

  logic signed [DELTA_W-1:0] a_q, a_d;
  logic signed [DELTA_W-1:0] b_q, b_d;
  logic signed [PROD_W-1:0]  a_ext;
  logic signed [PROD_W-1:0]  b_ext;

  always_comb begin
    a_d = a;
    b_d = b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Sign-extend to product width so the low 14 bits are the exact signed product.
  assign a_ext  = PROD_W'(a_q);
  assign b_ext  = PROD_W'(b_q);
  assign prod_c = a_ext * b_ext;

endmodule

// File: rtl/tt_um_emern_tri_setup.sv
// Triangle setup: edge deltas and signed determinant via one shared multiplier over two cycles.
// Optional macro TRI_SETUP_BACKFACE_CULL_EN drops negative-determinant triangles with a cull pulse.
module tt_um_emern_tri_setup
  import tt_um_emern_tri_setup_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  tt_um_emern_tri_setup_if.slave   bus
);

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      degenerate_q, degenerate_d;
  logic                      cull_q, cull_d;
  logic signed [DET_W-1:0]   det_q, det_d;
  logic signed [DELTA_W-1:0] dx10_q, dx10_d;
  logic signed [DELTA_W-1:0] dy10_q, dy10_d;
  logic signed [DELTA_W-1:0] dx20_q, dx20_d;
  logic signed [DELTA_W-1:0] dy20_q, dy20_d;
  logic signed [PROD_W-1:0]  p0_q, p0_d;

  logic signed [DELTA_W-1:0] new_dx10, new_dy10, new_dx20, new_dy20;
  logic signed [DELTA_W-1:0] mul_a, mul_b;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [PROD_W-1:0]  diff;

  assign new_dx10 = delta7(bus.x1, bus.x0);
  assign new_dy10 = delta7(bus.y1, bus.y0);
  assign new_dx20 = delta7(bus.x2, bus.x0);
  assign new_dy20 = delta7(bus.y2, bus.y0);

  tt_um_emern_smul7 u_mul (
    .clk    (clk),
    .rst    (rst),
    .a      (mul_a),
    .b      (mul_b),
    .prod_c (prod_c)
  );

  assign diff = p0_q - prod_c;

  // Next-state and output logic; operands are loaded one cycle ahead of their product.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    degenerate_d = 1'b0;
    cull_d       = 1'b0;
    det_d        = det_q;
    dx10_d       = dx10_q;
    dy10_d       = dy10_q;
    dx20_d       = dx20_q;
    dy20_d       = dy20_q;
    p0_d         = p0_q;
    mul_a        = dx20_q;
    mul_b        = dy10_q;

    case (state_q)
      ST_IDLE: begin
        mul_a = new_dx10;
        mul_b = new_dy20;
        if (bus.in_valid) begin
          dx10_d  = new_dx10;
          dy10_d  = new_dy10;
          dx20_d  = new_dx20;
          dy20_d  = new_dy20;
          state_d = ST_MUL0;
        end
      end
      ST_MUL0: begin
        p0_d    = prod_c;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        det_d = diff[DET_W-1:0];
        if (diff == '0) begin
          degenerate_d = 1'b1;
          state_d      = ST_IDLE;
        end
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        else if (diff[PROD_W-1]) begin
          cull_d  = 1'b1;
          state_d = ST_IDLE;
        end
`endif
        else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      degenerate_q <= 1'b0;
      cull_q       <= 1'b0;
      det_q        <= '0;
      dx10_q       <= '0;
      dy10_q       <= '0;
      dx20_q       <= '0;
      dy20_q       <= '0;
      p0_q         <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      degenerate_q <= degenerate_d;
      cull_q       <= cull_d;
      det_q        <= det_d;
      dx10_q       <= dx10_d;
      dy10_q       <= dy10_d;
      dx20_q       <= dx20_d;
      dy20_q       <= dy20_d;
      p0_q         <= p0_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.degenerate  = degenerate_q;
  assign bus.cull        = cull_q;
  assign bus.determinant = det_q;
  assign bus.dx10        = dx10_q;
  assign bus.dy10        = dy10_q;
  assign bus.dx20        = dx20_q;
  assign bus.dy20        = dy20_q;

endmodule

// File: tb/tb_tt_um_emern_tri_setup.sv
// Directed bench for tt_um_emern_tri_setup; expected values are hand-computed determinants.
module tb_tt_um_emern_tri_setup;

  logic clk;
  logic rst;
  int   tests;
  int   failures;

  tt_um_emern_tri_setup_if bus ();

  tt_um_emern_tri_setup dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one triangle for a single accepting cycle; returns in cycle N+1 (MUL0).
  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy);
    bus.x0 = 6'(ax); bus.y0 = 6'(ay);
    bus.x1 = 6'(bx); bus.y1 = 6'(by);
    bus.x2 = 6'(cx); bus.y2 = 6'(cy);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0;
    step();
    step();

    // Reset state
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_det",        {19'd0, bus.determinant}, 32'd0);
    chk("rst_degenerate", 32'(bus.degenerate), 32'd0);
    chk("rst_cull",       32'(bus.cull),       32'd0);
    chk("rst_dx10",       {25'd0, bus.dx10},   32'd0);
    rst = 1'b0;
    step();

    // Right triangle, counter-clockwise: det = +100
    bus.out_ready = 1'b1;
    send(0, 0, 10, 0, 0, 10);
    chk("t1_in_ready_busy", 32'(bus.in_ready),  32'd0);
    step();
    chk("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("t1_out_valid", 32'(bus.out_valid),     32'd1);
    chk("t1_det",       {19'd0, bus.determinant}, 32'd100);
    chk("t1_dx10",      {25'd0, bus.dx10},      32'd10);
    chk("t1_dy20",      {25'd0, bus.dy20},      32'd10);
    chk("t1_dx20",      {25'd0, bus.dx20},      32'd0);
    chk("t1_dy10",      {25'd0, bus.dy10},      32'd0);
    chk("t1_degenerate", 32'(bus.degenerate),   32'd0);
    step();
    chk("t1_drained_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_drained_ready", 32'(bus.in_ready),  32'd1);

    // Clockwise winding: det = -100
    send(0, 0, 0, 10, 10, 0);
    step();
    step();
`ifdef TRI_SETUP_BACKFACE_CULL_EN
    chk("t2_out_valid", 32'(bus.out_valid),  32'd0);
    chk("t2_cull",      32'(bus.cull),       32'd1);
    chk("t2_degen",     32'(bus.degenerate), 32'd0);
    chk("t2_in_ready",  32'(bus.in_ready),   32'd1);
    step();
    chk("t2_cull_pulse", 32'(bus.cull),      32'd0);
    chk("t2_no_valid",   32'(bus.out_valid), 32'd0);
`else
    chk("t2_out_valid", 32'(bus.out_valid),  32'd1);
    chk("t2_det",       {19'd0, bus.determinant}, 32'h1F9C);
    chk("t2_cull",      32'(bus.cull),       32'd0);
    step();
    chk("t2_drained",   32'(bus.out_valid),  32'd0);
`endif

    // Collinear: degenerate pulse, no output
    send(0, 0, 5, 5, 10, 10);
    step();
    step();
    chk("t3_degenerate", 32'(bus.degenerate), 32'd1);
    chk("t3_out_valid",  32'(bus.out_valid),  32'd0);
    chk("t3_in_ready",   32'(bus.in_ready),   32'd1);
    chk("t3_cull",       32'(bus.cull),       32'd0);
    step();
    chk("t3_degen_pulse", 32'(bus.degenerate), 32'd0);
    chk("t3_still_idle",  32'(bus.out_valid),  32'd0);

    // Extreme positive extents
    send(0, 0, 63, 0, 0, 47);
    step();
    step();
    chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_det",  {19'd0, bus.determinant}, 32'h0B91);
    chk("t4_dx10", {25'd0, bus.dx10}, 32'h3F);
    chk("t4_dy20", {25'd0, bus.dy20}, 32'h2F);
    step();

    // Extreme negative deltas, same positive determinant
    send(63, 47, 0, 47, 63, 0);
    step();
    step();
    chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_det",  {19'd0, bus.determinant}, 32'h0B91);
    chk("t5_dx10", {25'd0, bus.dx10}, 32'h41);
    chk("t5_dy20", {25'd0, bus.dy20}, 32'h51);
    chk("t5_dy10", {25'd0, bus.dy10}, 32'h00);
    step();

    // Backpressure: det = 6*8 - 2*1 = 46, held for 5 stalled cycles
    bus.out_ready = 1'b0;
    send(1, 1, 7, 2, 3, 9);
    step();
    step();
    chk("t6_out_valid", 32'(bus.out_valid), 32'd1);
    bus.x0 = 6'd0; bus.y0 = 6'd0;
    bus.x1 = 6'd10; bus.y1 = 6'd0;
    bus.x2 = 6'd0; bus.y2 = 6'd10;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t6_hold_det",   {19'd0, bus.determinant}, 32'd46);
      chk("t6_hold_busy",  32'(bus.in_ready),  32'd0);
    end
    chk("t6_hold_dx10", {25'd0, bus.dx10}, 32'd6);
    bus.out_ready = 1'b1;
    step();
    chk("t6_release_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_release_ready", 32'(bus.in_ready),  32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t6_second_busy", 32'(bus.in_ready), 32'd0);
    step();
    step();
    chk("t6_second_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_second_det",   {19'd0, bus.determinant}, 32'd100);
    step();

    // Reset during MUL1 aborts the triangle
    send(0, 0, 10, 0, 0, 10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_out_valid", 32'(bus.out_valid),  32'd0);
    chk("t7_in_ready",  32'(bus.in_ready),   32'd1);
    chk("t7_det",       {19'd0, bus.determinant}, 32'd0);
    chk("t7_degen",     32'(bus.degenerate), 32'd0);
    chk("t7_cull",      32'(bus.cull),       32'd0);
    chk("t7_dx10",      {25'd0, bus.dx10},   32'd0);
    step();
    chk("t7_no_late_valid", 32'(bus.out_valid),  32'd0);
    chk("t7_no_late_degen", 32'(bus.degenerate), 32'd0);

    // Recovery after abort
    send(0, 0, 10, 0, 0, 10);
    step();
    step();
    chk("t8_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t8_det",       {19'd0, bus.determinant}, 32'd100);
    step();
    chk("t8_drained",   32'(bus.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_emern_tri_setup.md
Name: tt_um_emern_tri_setup

Overview:
- Triangle setup stage directly upstream of the determinant-inverse stage.
- Accepts one screen-space triangle (three vertices in the 64x48 pixel space) over a valid/ready handshake.
- Computes the signed edge-function determinant with a single shared multiplier over two cycles.
- Presents a registered 13-bit signed determinant plus edge deltas to the inverse stage and the rasteriser; zero-area triangles are discarded here so the inverse stage never sees det = 0.

Parameters:
- X_W, 6, vertex x width (unsigned, 0..63)
- Y_W, 6, vertex y width (unsigned, 0..47 legal)
- DET_W, 13, determinant width (signed two's complement)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  triangle present on vertex inputs
- in_ready  out  1  block can accept a triangle
- x0, x1, x2  in  6 each  vertex x coordinates
- y0, y1, y2  in  6 each  vertex y coordinates
- out_valid  out  1  determinant/deltas valid
- out_ready  in  1  downstream accepts result
- determinant  out  13  signed (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0)
- dx10, dy10, dx20, dy20  out  7 each  signed edge deltas, registered
- degenerate  out  1  one-cycle pulse when a zero-area triangle is dropped
- cull  out  1  one-cycle pulse when a triangle is culled (feature only; tied 0 otherwise)

Behaviour:
- Reset, synchronous, active-high, takes priority over all else:
  - state = IDLE; in_ready = 1; out_valid = 0; degenerate = 0; cull = 0; determinant = 0; all deltas = 0.
- FSM states IDLE, MUL0, MUL1, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture deltas (zero-extend to 8 bits, subtract, keep low 7 bits; range -63..63 x, -47..47 y) and go to MUL0.
- MUL0:
  - in_ready = 0.
  - p0 = dx10 * dy20 (signed 7x7, 14-bit product) registered; go to MUL1.
- MUL1:
  - p1 = dx20 * dy10 through the same multiplier instance.
  - Form diff = p0 - p1 in 14 bits; determinant = diff[12:0]. For legal inputs |diff| <= 63*47 = 2961, so no overflow.
  - If diff == 0: pulse degenerate for 1 cycle, return to IDLE, out_valid stays 0.
  - Else: go to DONE with out_valid = 1.
- DONE:
  - out_valid = 1; determinant and deltas held stable.
  - When out_ready = 1: clear out_valid, go to IDLE.
  - in_ready = 0 throughout DONE; no skid buffer, single triangle in flight.
- Latency: handshake accepted at cycle N, out_valid = 1 from cycle N+3. Minimum initiation interval 4 cycles (out_ready held high).
- out_ready asserted while out_valid = 0 is ignored.
- in_valid while in_ready = 0 is ignored; the upstream holds its data.
- y > 47 is out of contract; overflow of determinant[12] is undefined but must not hang the FSM.
- Reset mid-operation (MUL0/MUL1/DONE) aborts the triangle; no out_valid or pulse is emitted for it.

Optional Feature:
- Macro TRI_SETUP_BACKFACE_CULL_EN.
- Defined: in MUL1, a negative determinant (diff[13] = 1) is dropped like a degenerate triangle: cull pulses 1 cycle, return to IDLE, out_valid stays 0. Zero takes the degenerate path; degenerate and cull never pulse together.
- Undefined: cull is tied 0; negative determinants pass downstream and the inverse stage handles the sign.

Decomposition:
- Shared package holds:
  - coordinate widths, DET_W, delta width 7
  - screen limits 64 and 48
  - FSM state enum (2 bits)
- Sub-module tt_um_emern_smul7: registered signed 7x7 -> 14 multiplier with operand muxing done by the parent, so one multiplier is instantiated.

Test Plan:
- Vertices (0,0),(10,0),(0,10), out_ready = 1 -> out_valid 3 cycles after accept; determinant = +100; dx10 = 10, dy20 = 10, dx20 = 0, dy10 = 0.
- Vertices (0,0),(0,10),(10,0) -> determinant = -100 (13'h1F9C). With TRI_SETUP_BACKFACE_CULL_EN: no out_valid, cull pulses once, in_ready back high the following cycle.
- Collinear (0,0),(5,5),(10,10) -> degenerate pulses once, out_valid never asserts, FSM back to IDLE.
- Extreme (0,0),(63,0),(0,47) -> determinant = 2961 (13'h0B91); (63,47),(0,47),(63,0) -> determinant = 2961, check sign and width.
- Backpressure: out_ready = 0 for 5 cycles after out_valid -> outputs stable, in_ready = 0, a second in_valid is not accepted until the cycle after the out handshake.
- rst asserted in MUL1 -> next cycle out_valid = 0, in_ready = 1, determinant = 0, no degenerate or cull pulse.
